ssm_scan_ctrl: RTL and testbench



---
 rtl/ssm_scan_ctrl.sv | 111 +++++++++++
 tb/tb_ssm_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ssm_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame snapshot and blink.
// Define SSM_LZB_EN to blank a leading zero in digit 3.
module ssm_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD_CYC  = 4,
  parameter int BLINK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  dec_sel,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg_out,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  localparam int CMAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int FW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   snap, snap_nxt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          frame_tick;
  logic [3:0]    cur_dig;
  logic          lz_blank;
  logic          visible;

  assign frame_tick  = (state == BLANK) && (idx == 2'd0)
                     && (cnt == '0);
  assign frame_start = frame_tick;
  assign snap_nxt    = frame_tick ? digits : snap;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      BLANK: begin
        if (cnt == CW'(DEAD_CYC - 1)) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end
      end
    endcase
  end

  assign cur_dig = snap_nxt[{idx_nxt, 2'b00} +: 4];

`ifdef SSM_LZB_EN
  assign lz_blank = (idx_nxt == 2'd3) && (cur_dig == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  assign visible = (cur_dig <= 4'd9)
                 && !(blink_mask[idx_nxt] && blink_phase)
                 && !lz_blank;

  // outputs are loaded for the state being entered, so they move with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      idx         <= 2'd0;
      cnt         <= '0;
      snap        <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      an_n        <= 4'hF;
      seg_out     <= 7'h7F;
      dec_sel     <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (frame_tick) begin
        snap <= digits;
        if (frame_cnt == FW'(BLINK_DIV - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
      if (state_nxt == SHOW) begin
        an_n    <= ~(4'b0001 << idx_nxt);
        seg_out <= visible ? seg_in : 7'h7F;
      end else begin
        an_n    <= 4'hF;
        seg_out <= 7'h7F;
        dec_sel <= cur_dig;
      end
    end
  end

endmodule

// File: tb/tb_ssm_scan_ctrl.sv
// Bench for ssm_scan_ctrl: per-cycle expectations queued and popped.
// Honours SSM_LZB_EN for the leading-zero expectation.
module tb_ssm_scan_ctrl;

  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BD = 2;
  localparam int SLOT = SD + DC;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  dec_sel;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_n;
  logic        frame_start;

  int errors;
  int checks;
  int frame_no;
  exp_t q[$];

  ssm_scan_ctrl #(
    .SCAN_DIV (SD),
    .DEAD_CYC (DC),
    .BLINK_DIV(BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blink_mask (blink_mask),
    .dec_sel    (dec_sel),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'b1000000;
      4'd1: dec7 = 7'b1111001;
      4'd2: dec7 = 7'b0100100;
      4'd3: dec7 = 7'b0110000;
      4'd4: dec7 = 7'b0011001;
      4'd5: dec7 = 7'b0010010;
      4'd6: dec7 = 7'b0000010;
      4'd7: dec7 = 7'b1111000;
      4'd8: dec7 = 7'b0000000;
      4'd9: dec7 = 7'b0010000;
      default: dec7 = 7'b0000110;
    endcase
  endfunction

  always_comb seg_in = dec7(dec_sel);

  function automatic exp_t model(input int t, input logic [15:0] s,
                                 input logic [3:0] m, input int f);
    exp_t e;
    int slot;
    int pos;
    logic [3:0] d;
    logic ph;
    logic blank;
    slot = t / SLOT;
    pos  = t % SLOT;
    ph   = (((f + 1) / BD) % 2) == 1;
    d    = s[slot*4 +: 4];
    e.fs = (t == 0);
    if (pos < DC) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
    end else begin
      e.an  = ~(4'b0001 << slot);
      blank = (d > 4'd9) || (m[slot] && ph);
`ifdef SSM_LZB_EN
      if (slot == 3 && d == 4'd0) blank = 1'b1;
`endif
      e.seg = blank ? 7'h7F : dec7(d);
    end
    return e;
  endfunction

  // Runs from the start of a frame (#1 after its first edge) for ncyc cycles.
  task automatic run_frame(input logic chg, input logic [15:0] chg_val,
                           input int ncyc, input int rst_at);
    logic [15:0] s;
    exp_t e;
    exp_t got;
    s = digits;
    for (int t = 0; t < ncyc; t++) begin
      if (chg && t == 15) digits = chg_val;
      if (t == rst_at) rst = 1'b1;
      q.push_back(model(t, s, blink_mask, frame_no));
      @(negedge clk);
      got = {an_n, seg_out, frame_start};
      e = q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scan f%0d t%0d: got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b",
                 frame_no, t, got.an, got.seg, got.fs, e.an, e.seg, e.fs);
      end
      if (t == 1) begin
        checks++;
        if (dec_sel !== s[3:0]) begin
          errors++;
          $display("FAIL dec_sel f%0d: got %h want %h", frame_no, dec_sel, s[3:0]);
        end
      end
      @(posedge clk);
      #1;
    end
    if (rst_at >= 0) rst = 1'b0;
    if (ncyc == FRAME) frame_no++;
    else frame_no = 0;
  endtask

  task automatic test_reset(input logic [15:0] d);
    rst = 1'b1;
    digits = d;
    blink_mask = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (an_n !== 4'hF || seg_out !== 7'h7F || dec_sel !== 4'd0) begin
        errors++;
        $display("FAIL reset: got an=%b seg=%b dec=%h want 1111 1111111 0",
                 an_n, seg_out, dec_sel);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_no = 0;
  endtask

  task automatic test_scan();
    test_reset(16'h1234);
    run_frame(1'b1, 16'h5678, FRAME, -1);
  endtask

  task automatic test_digit_change();
    run_frame(1'b0, 16'h0, FRAME, -1);
  endtask

  task automatic test_invalid();
    digits = 16'h12A4;
    run_frame(1'b0, 16'h0, FRAME, -1);
  endtask

  task automatic test_blink();
    test_reset(16'h1234);
    blink_mask = 4'b0001;
    for (int f = 0; f < 5; f++) run_frame(1'b0, 16'h0, FRAME, -1);
    blink_mask = 4'b0000;
  endtask

  task automatic test_mid_reset_lzb();
    test_reset(16'h1234);
    run_frame(1'b0, 16'h0, 26, 25);
    digits = 16'h0930;
    run_frame(1'b0, 16'h0, FRAME, -1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    frame_no = 0;
    rst = 1'b1;
    digits = 16'h0;
    blink_mask = 4'h0;
    #1;
    test_scan();
    test_digit_change();
    test_invalid();
    test_blink();
    test_mid_reset_lzb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
